fifo_sync_param: RTL and testbench
==================================

Name: fifo_sync_param

Overview:
Parametrised single-clock circular FIFO, the successor to the fixed 4-bit circular FIFO. Generalised in data width and depth, with:
- selectable output mode: registered or first-word-fall-through (FWFT)
- occupancy count and programmable almost-full / almost-empty flags
- synchronous flush
- sticky overflow/underflow error flags

It sits between a producer and a consumer in the same clock domain and is the buffering primitive for datapaths in this codebase.

Parameters:
WIDTH, 4, data word width in bits (>=1)
DEPTH, 8, number of entries; power of two, >=2
AF_LEVEL, 6, almost_full asserts when count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)
FWFT, 0, 0 = registered read (1-cycle latency); 1 = first-word-fall-through

Ports:
clk  input  1  single clock, rising edge
reset  input  1  asynchronous, active-low reset
data_in  input  WIDTH  write data
write  input  1  write request
read  input  1  read request
flush  input  1  synchronous clear of FIFO contents
clr_err  input  1  synchronous clear of sticky error flags
data_out  output  WIDTH  read data
empty  output  1  no entries
full  output  1  DEPTH entries
almost_full  output  1  count >= AF_LEVEL
almost_empty  output  1  count <= AE_LEVEL
count  output  clog2(DEPTH)+1  current occupancy 0..DEPTH
overflow  output  1  sticky: write attempted while full and not accepted
underflow  output  1  sticky: read attempted while empty

Behaviour:
- Reset (reset=0, async):
  - pointers, count and data_out = 0
  - empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0 ? 1 : 0), overflow=0, underflow=0
  - memory contents undefined
  - reset mid-operation discards all entries
- Pointers: wr_ptr and rd_ptr are ADDR_W+1 bits, ADDR_W = clog2(DEPTH). The MSB distinguishes wrap.
  - empty = (wr_ptr == rd_ptr)
  - full = (ADDR_W-bit indices equal, MSBs differ)
  - Pointers wrap naturally modulo 2*DEPTH; index = ptr[ADDR_W-1:0].
- Accept rules, evaluated on each rising edge:
  - do_rd = read & !empty
  - do_wr = write & (!full | do_rd)
  - A write while full is accepted only when a read occurs in the same cycle; count is then unchanged.
  - Read and write while empty: write accepted, read rejected, underflow set.
- count: +1 on do_wr only, -1 on do_rd only, unchanged on both or neither. All flags are registered from next-state count, so they are valid the cycle after the edge.
- FWFT=0:
  - on do_rd, data_out <= mem[rd_idx] at the edge (valid the cycle after read is sampled)
  - otherwise data_out holds its last value
- FWFT=1:
  - data_out = mem[rd_idx] whenever !empty; read acts as pop
  - a word written into an empty FIFO appears on data_out the cycle after the write edge
  - data_out = 0 while empty
- Errors:
  - overflow <= 1 when write & full & !do_rd
  - underflow <= 1 when read & empty
  - both stay set until clr_err=1 or reset; clr_err has priority over a new set in the same cycle
- Flush (synchronous, priority over read/write):
  - pointers and count <= 0, empty=1; read/write in that cycle are ignored and raise no errors
  - data_out <= 0 in both modes
- Simultaneous read/write at wrap boundary: both pointers wrap independently; no bubble.

Decomposition:
- Shared package fifo_pkg:
  - function clog2
  - localparam-style constants for default WIDTH/DEPTH
  - typedef of the pointer width helper
- One natural sub-module: fifo_mem_dp. Simple dual-port register array, one write port, one asynchronous read port, parametrised WIDTH/DEPTH. All control stays in fifo_sync_param.

Test Plan:
1. Reset then fill: WIDTH=4, DEPTH=8, write 1..8 with read=0 -> count steps 1..8; almost_full at count=6; full=1 after 8th write; empty=0 after first write.
2. Overflow: write 9 while full, read=0 -> data unchanged, count=8, overflow=1; clr_err=1 -> overflow=0.
3. Drain, FWFT=0: read for 8 cycles -> data_out 1..8, each one cycle after read sampled; empty=1 after 8th; almost_empty at count=2; extra read -> underflow=1, data_out stays 8.
4. Simultaneous read/write: with full at 8, read and write data 9 -> count stays 8, full stays 1, no overflow. Then read 8 more times -> data_out 2..9 (wrap verified).
5. FWFT=1: write 5 into empty FIFO -> data_out=5 next cycle with empty=0. Read -> empty=1, data_out=0.
6. Flush and async reset: with 5 entries, flush plus write -> count=0, empty=1, write ignored, no error. Refill 3 entries, pull reset=0 between edges -> outputs clear immediately; count=0, empty=1.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parametrised synchronous FIFO.
// Provides clog2, default sizes and the pointer-width helper.
package fifo_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_DEPTH = 8;

    typedef int unsigned ptr_w_t;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    // Pointers carry one extra wrap bit above the index.
    function automatic ptr_w_t ptr_width(input int depth);
        return ptr_w_t'(clog2(depth) + 1);
    endfunction

endpackage

// File: rtl/fifo_mem_dp.sv
// Dual-port register array: one synchronous write port, one async read.
// Ports: clk, wr_en/wr_addr/wr_data (write), rd_addr/rd_data (read).
module fifo_mem_dp
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_sync_param.sv
// Single-clock circular FIFO with registered or FWFT read, occupancy
// count, almost flags, synchronous flush and sticky error flags.
// Ports: clk, reset (async active-low), data_in/write, read/data_out,
// flush, clr_err, empty/full/almost_full/almost_empty/count,
// overflow/underflow.
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = 6,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   data_in,
    input  logic               write,
    input  logic               read,
    input  logic               flush,
    input  logic               clr_err,
    output logic [WIDTH-1:0]   data_out,
    output logic               empty,
    output logic               full,
    output logic               almost_full,
    output logic               almost_empty,
    output logic [clog2(DEPTH):0] count,
    output logic               overflow,
    output logic               underflow
);

    localparam int AW = clog2(DEPTH);
    localparam int PW = int'(ptr_width(DEPTH));

    localparam logic [PW-1:0] AF_L = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AE_L = PW'(AE_LEVEL);
    localparam logic [PW-1:0] ONE  = PW'(1);

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_nxt;
    logic [PW-1:0]    rd_nxt;
    logic [PW-1:0]    cnt_nxt;
    logic             do_rd;
    logic             do_wr;
    logic             ovf_set;
    logic             unf_set;
    logic [WIDTH-1:0] mem_rd;

    // A full FIFO still accepts a write when a pop frees a slot in
    // the same cycle; flush suppresses every transfer and error.
    always_comb begin
        do_rd   = read & ~empty & ~flush;
        do_wr   = write & (~full | do_rd) & ~flush;
        ovf_set = write & full & ~do_rd & ~flush;
        unf_set = read & empty & ~flush;
        wr_nxt  = wr_ptr;
        rd_nxt  = rd_ptr;
        cnt_nxt = count;
        if (do_wr) begin
            wr_nxt = wr_ptr + ONE;
        end
        if (do_rd) begin
            rd_nxt = rd_ptr + ONE;
        end
        unique case ({do_wr, do_rd})
            2'b10:   cnt_nxt = count + ONE;
            2'b01:   cnt_nxt = count - ONE;
            default: cnt_nxt = count;
        endcase
        if (flush) begin
            wr_nxt  = '0;
            rd_nxt  = '0;
            cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_full  <= (AF_LEVEL == 0);
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            wr_ptr       <= wr_nxt;
            rd_ptr       <= rd_nxt;
            count        <= cnt_nxt;
            empty        <= (wr_nxt == rd_nxt);
            full         <= (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]) &&
                            (wr_nxt[AW] != rd_nxt[AW]);
            almost_full  <= (cnt_nxt >= AF_L);
            almost_empty <= (cnt_nxt <= AE_L);
            // Clear wins over a set arriving in the same cycle.
            overflow     <= clr_err ? 1'b0 : (overflow | ovf_set);
            underflow    <= clr_err ? 1'b0 : (underflow | unf_set);
        end
    end

    fifo_mem_dp #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (do_wr),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data (data_in),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (mem_rd)
    );

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is exposed directly; zero while nothing is held.
            assign data_out = empty ? '0 : mem_rd;
        end else begin : g_reg
            logic [WIDTH-1:0] dout_q;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    dout_q <= '0;
                end else if (flush) begin
                    dout_q <= '0;
                end else if (do_rd) begin
                    dout_q <= mem_rd;
                end
            end
            assign data_out = dout_q;
        end
    endgenerate

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param: registered (u0) and FWFT (u1)
// instances, one task per scenario with hand-computed expectations.
module tb_fifo_sync_param;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] din0, din1;
    logic       wr0, rd0, fl0, ce0;
    logic       wr1, rd1, fl1, ce1;
    logic [3:0] dout0, dout1;
    logic       e0, f0, af0, ae0, ov0, un0;
    logic       e1, f1, af1, ae1, ov1, un1;
    logic [3:0] cnt0, cnt1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fifo_sync_param #(.WIDTH(4), .DEPTH(8), .AF_LEVEL(6),
                      .AE_LEVEL(2), .FWFT(0)) u0 (
        .clk(clk), .reset(reset), .data_in(din0), .write(wr0),
        .read(rd0), .flush(fl0), .clr_err(ce0), .data_out(dout0),
        .empty(e0), .full(f0), .almost_full(af0),
        .almost_empty(ae0), .count(cnt0), .overflow(ov0),
        .underflow(un0)
    );

    fifo_sync_param #(.WIDTH(4), .DEPTH(8), .AF_LEVEL(6),
                      .AE_LEVEL(2), .FWFT(1)) u1 (
        .clk(clk), .reset(reset), .data_in(din1), .write(wr1),
        .read(rd1), .flush(fl1), .clr_err(ce1), .data_out(dout1),
        .empty(e1), .full(f1), .almost_full(af1),
        .almost_empty(ae1), .count(cnt1), .overflow(ov1),
        .underflow(un1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push0(input logic [3:0] v);
        din0 = v; wr0 = 1'b1;
        tick();
        wr0 = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        din0 = '0; wr0 = 0; rd0 = 0; fl0 = 0; ce0 = 0;
        din1 = '0; wr1 = 0; rd1 = 0; fl1 = 0; ce1 = 0;
        tick(); tick();
        total++;
        if ({e0, f0, af0, ae0, ov0, un0} !== 6'b100100) begin
            bad++;
            $display("FAIL reset_flags0: got %b want 100100",
                     {e0, f0, af0, ae0, ov0, un0});
        end
        total++;
        if (cnt0 !== 4'd0 || dout0 !== 4'd0) begin
            bad++;
            $display("FAIL reset_cnt_dout0: got %0d/%0d want 0/0",
                     cnt0, dout0);
        end
        total++;
        if ({e1, f1, af1, ae1, ov1, un1} !== 6'b100100 ||
            cnt1 !== 4'd0 || dout1 !== 4'd0) begin
            bad++;
            $display("FAIL reset_u1: flags %b cnt %0d dout %0d",
                     {e1, f1, af1, ae1, ov1, un1}, cnt1, dout1);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 8; i++) begin
            push0(4'(i));
            total++;
            if (cnt0 !== 4'(i)) begin
                bad++;
                $display("FAIL fill_count: got %0d want %0d", cnt0, i);
            end
            total++;
            if (f0 !== (i == 8) || af0 !== (i >= 6) ||
                ae0 !== (i <= 2) || e0 !== 1'b0) begin
                bad++;
                $display("FAIL fill_flags at %0d: f=%b af=%b ae=%b e=%b",
                         i, f0, af0, ae0, e0);
            end
        end
    endtask

    task automatic test_overflow();
        push0(4'd9);
        total++;
        if (cnt0 !== 4'd8 || ov0 !== 1'b1 || f0 !== 1'b1) begin
            bad++;
            $display("FAIL overflow_set: cnt %0d ov %b f %b want 8 1 1",
                     cnt0, ov0, f0);
        end
        ce0 = 1'b1;
        tick();
        ce0 = 1'b0;
        total++;
        if (ov0 !== 1'b0) begin
            bad++;
            $display("FAIL overflow_clr: got %b want 0", ov0);
        end
    endtask

    task automatic test_drain();
        rd0 = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            total++;
            if (dout0 !== 4'(i)) begin
                bad++;
                $display("FAIL drain_data: got %0d want %0d", dout0, i);
            end
            total++;
            if (cnt0 !== 4'(8 - i) || ae0 !== ((8 - i) <= 2) ||
                e0 !== (i == 8)) begin
                bad++;
                $display("FAIL drain_flags at %0d: cnt %0d ae %b e %b",
                         i, cnt0, ae0, e0);
            end
        end
        tick();
        rd0 = 1'b0;
        total++;
        if (un0 !== 1'b1 || dout0 !== 4'd8 || cnt0 !== 4'd0) begin
            bad++;
            $display("FAIL underflow: un %b dout %0d cnt %0d want 1 8 0",
                     un0, dout0, cnt0);
        end
        ce0 = 1'b1;
        tick();
        ce0 = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 8; i++) push0(4'(i));
        din0 = 4'd9; wr0 = 1'b1; rd0 = 1'b1;
        tick();
        wr0 = 1'b0;
        total++;
        if (cnt0 !== 4'd8 || f0 !== 1'b1 || ov0 !== 1'b0 ||
            dout0 !== 4'd1) begin
            bad++;
            $display("FAIL rw_full: cnt %0d f %b ov %b dout %0d",
                     cnt0, f0, ov0, dout0);
        end
        for (int i = 1; i <= 8; i++) begin
            tick();
            total++;
            if (dout0 !== 4'(i + 1)) begin
                bad++;
                $display("FAIL wrap_data: got %0d want %0d", dout0, i + 1);
            end
        end
        rd0 = 1'b0;
        total++;
        if (e0 !== 1'b1 || cnt0 !== 4'd0) begin
            bad++;
            $display("FAIL wrap_empty: e %b cnt %0d", e0, cnt0);
        end
    endtask

    task automatic test_empty_rw();
        din0 = 4'd3; wr0 = 1'b1; rd0 = 1'b1;
        tick();
        wr0 = 1'b0; rd0 = 1'b0;
        total++;
        if (cnt0 !== 4'd1 || un0 !== 1'b1 || dout0 !== 4'd9 ||
            e0 !== 1'b0) begin
            bad++;
            $display("FAIL empty_rw: cnt %0d un %b dout %0d e %b",
                     cnt0, un0, dout0, e0);
        end
        ce0 = 1'b1;
        tick();
        ce0 = 1'b0;
        rd0 = 1'b1;
        tick();
        rd0 = 1'b0;
        total++;
        if (dout0 !== 4'd3 || e0 !== 1'b1 || un0 !== 1'b0) begin
            bad++;
            $display("FAIL empty_rw_pop: dout %0d e %b un %b",
                     dout0, e0, un0);
        end
    endtask

    task automatic test_fwft();
        total++;
        if (dout1 !== 4'd0 || e1 !== 1'b1) begin
            bad++;
            $display("FAIL fwft_idle: dout %0d e %b", dout1, e1);
        end
        din1 = 4'd5; wr1 = 1'b1;
        tick();
        wr1 = 1'b0;
        total++;
        if (dout1 !== 4'd5 || e1 !== 1'b0) begin
            bad++;
            $display("FAIL fwft_show: dout %0d e %b want 5 0", dout1, e1);
        end
        rd1 = 1'b1;
        tick();
        rd1 = 1'b0;
        total++;
        if (dout1 !== 4'd0 || e1 !== 1'b1) begin
            bad++;
            $display("FAIL fwft_pop: dout %0d e %b want 0 1", dout1, e1);
        end
        din1 = 4'd6; wr1 = 1'b1;
        tick();
        din1 = 4'd7;
        tick();
        wr1 = 1'b0;
        total++;
        if (dout1 !== 4'd6 || cnt1 !== 4'd2) begin
            bad++;
            $display("FAIL fwft_head: dout %0d cnt %0d want 6 2",
                     dout1, cnt1);
        end
        rd1 = 1'b1;
        tick();
        rd1 = 1'b0;
        total++;
        if (dout1 !== 4'd7 || cnt1 !== 4'd1) begin
            bad++;
            $display("FAIL fwft_next: dout %0d cnt %0d want 7 1",
                     dout1, cnt1);
        end
    endtask

    task automatic test_flush();
        for (int i = 1; i <= 5; i++) push0(4'(i));
        rd0 = 1'b1;
        tick();
        rd0 = 1'b0;
        fl0 = 1'b1; wr0 = 1'b1; din0 = 4'd10;
        tick();
        fl0 = 1'b0; wr0 = 1'b0;
        total++;
        if (cnt0 !== 4'd0 || e0 !== 1'b1 || ov0 !== 1'b0 ||
            un0 !== 1'b0 || dout0 !== 4'd0) begin
            bad++;
            $display("FAIL flush: cnt %0d e %b ov %b un %b dout %0d",
                     cnt0, e0, ov0, un0, dout0);
        end
        rd0 = 1'b1;
        tick();
        total++;
        if (un0 !== 1'b1) begin
            bad++;
            $display("FAIL flush_ignored_write: un %b want 1", un0);
        end
        ce0 = 1'b1;
        tick();
        ce0 = 1'b0; rd0 = 1'b0;
        total++;
        if (un0 !== 1'b0) begin
            bad++;
            $display("FAIL clr_priority: un %b want 0", un0);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 1; i <= 3; i++) push0(4'(i));
        rd0 = 1'b1;
        tick();
        rd0 = 1'b0;
        total++;
        if (dout0 !== 4'd1 || cnt0 !== 4'd2) begin
            bad++;
            $display("FAIL prereset: dout %0d cnt %0d want 1 2",
                     dout0, cnt0);
        end
        #2;
        reset = 1'b0;
        #1;
        total++;
        if (cnt0 !== 4'd0 || e0 !== 1'b1 || dout0 !== 4'd0) begin
            bad++;
            $display("FAIL async_reset0: cnt %0d e %b dout %0d",
                     cnt0, e0, dout0);
        end
        total++;
        if (cnt1 !== 4'd0 || e1 !== 1'b1 || dout1 !== 4'd0) begin
            bad++;
            $display("FAIL async_reset1: cnt %0d e %b dout %0d",
                     cnt1, e1, dout1);
        end
        #1;
        reset = 1'b1;
        tick();
        total++;
        if (cnt0 !== 4'd0 || e0 !== 1'b1) begin
            bad++;
            $display("FAIL post_reset: cnt %0d e %b", cnt0, e0);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_drain();
        test_back_to_back();
        test_empty_rw();
        test_fwft();
        test_flush();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
